// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_fetch_unit_pkg                                               |
// | Brief    : PCSel encodings, NOP/JAL constants and fetch FSM state type.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package pc_fetch_unit_pkg;

  localparam logic [1:0]  c_pcsel_pc4 = 2'b00;
  localparam logic [1:0]  c_pcsel_jal = 2'b01;
  localparam logic [1:0]  c_pcsel_br  = 2'b10;

  localparam logic [31:0] c_nop_instr = 32'h0000_0013;
  localparam logic [6:0]  c_opc_jal   = 7'b1101111;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_t;

  // Fetch targets are always word aligned; low bits from the resolvers are ignored.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_instr_skid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_fetch_unit_instr_skid_reg                                    |
// | Brief    : 32-bit instruction hold register with bypass mux to IMEM data.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pc_fetch_unit_instr_skid_reg
  import pc_fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        use_held,
  input  logic [31:0] rdata,
  output logic [31:0] instr
);

  logic [31:0] r_held;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_held <= c_nop_instr;
    end else if (capture) begin
      r_held <= rdata;
    end
  end

  assign instr = use_held ? r_held : rdata;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pc_fetch_unit                                                   |
// | Brief    : Fetch PC, synchronous IMEM read port and IF/ID outputs, with    |
// |            PCSel redirects and stall skid. FETCH_PERF_EN adds counters.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [1:0]         pc_sel,
  input  logic [31:0]        jal_target,
  input  logic [31:0]        br_target,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc_id,
  output logic [31:0]        instr_id,
  output logic               valid_id,
  output logic               is_jal_id,
  output logic               flush_id,
  output logic [31:0]        redirect_cnt,
  output logic [31:0]        stall_cnt
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc_f;
  logic [31:0]  r_pc_id;
  logic         r_valid_id;
  logic [31:0]  w_pc_next;
  logic         w_redirect;
  logic         w_fetch;
  logic         w_capture;
  logic         w_use_held;
  logic         w_active;
  logic [31:0]  w_skid_instr;

  assign w_redirect = (pc_sel == c_pcsel_br) || (pc_sel == c_pcsel_jal);
  assign w_active   = (r_state != ST_BOOT);

  always_comb begin
    w_pc_next    = r_pc_f + 32'd4;
    w_state_next = r_state;
    w_fetch      = 1'b0;
    w_capture    = 1'b0;
    w_use_held   = 1'b0;

    case (pc_sel)
      c_pcsel_br:  w_pc_next = align_word(br_target);
      c_pcsel_jal: w_pc_next = align_word(jal_target);
      default:     ;
    endcase

    // A redirect always fetches, even under stall, and drops any held instruction.
    case (r_state)
      ST_BOOT: begin
        w_pc_next    = RESET_PC;
        w_fetch      = 1'b1;
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_redirect || !stall) begin
          w_fetch = 1'b1;
        end else begin
          w_capture    = 1'b1;
          w_state_next = ST_STALL;
        end
      end
      ST_STALL: begin
        w_use_held = 1'b1;
        if (w_redirect || !stall) begin
          w_fetch      = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      default: w_state_next = ST_BOOT;
    endcase
  end

  // pc_f tracks the address whose data sits on the IMEM output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_BOOT;
      r_pc_f     <= RESET_PC;
      r_pc_id    <= 32'd0;
      r_valid_id <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_fetch) begin
        r_pc_f     <= w_pc_next;
        r_pc_id    <= w_pc_next;
        r_valid_id <= 1'b1;
      end
    end
  end

  pc_fetch_unit_instr_skid_reg u_skid (
    .clk      (clk),
    .rst      (rst),
    .capture  (w_capture),
    .use_held (w_use_held),
    .rdata    (imem_rdata),
    .instr    (w_skid_instr)
  );

  assign imem_en   = w_fetch & ~rst;
  assign imem_addr = w_pc_next[IMEM_AW+1:2];
  assign pc_id     = r_pc_id;
  assign valid_id  = r_valid_id;
  assign instr_id  = r_valid_id ? w_skid_instr : c_nop_instr;
  assign is_jal_id = r_valid_id && (instr_id[6:0] == c_opc_jal);
  assign flush_id  = (pc_sel != c_pcsel_pc4) && w_active;

`ifdef FETCH_PERF_EN
  logic [31:0] r_redirect_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect_cnt <= 32'd0;
      r_stall_cnt    <= 32'd0;
    end else if (w_active) begin
      if (pc_sel != c_pcsel_pc4) r_redirect_cnt <= r_redirect_cnt + 32'd1;
      if (stall)                 r_stall_cnt    <= r_stall_cnt + 32'd1;
    end
  end

  assign redirect_cnt = r_redirect_cnt;
  assign stall_cnt    = r_stall_cnt;
`else
  assign redirect_cnt = 32'd0;
  assign stall_cnt    = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pc_fetch_unit                                                |
// | Brief    : Directed scoreboard bench for pc_fetch_unit with an IMEM model. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pc_fetch_unit;

  localparam int          AW       = 14;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [6:0]  OPC_JAL  = 7'b1101111;
  localparam logic [6:0]  OPC_ADDI = 7'b0010011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        jal;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall = 1'b0;
  logic [1:0]    pc_sel = 2'b00;
  logic [31:0]   jal_target = 32'd0;
  logic [31:0]   br_target = 32'd0;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = 32'd0;
  logic [31:0]   pc_id;
  logic [31:0]   instr_id;
  logic          valid_id;
  logic          is_jal_id;
  logic          flush_id;
  logic [31:0]   redirect_cnt;
  logic [31:0]   stall_cnt;

  int   errors = 0;
  int   checks = 0;
  int   exp_redir = 0;
  int   exp_stall = 0;
  exp_t sb[$];

  pc_fetch_unit #(.RESET_PC(32'h0000_2000), .IMEM_AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .pc_sel       (pc_sel),
    .jal_target   (jal_target),
    .br_target    (br_target),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .pc_id        (pc_id),
    .instr_id     (instr_id),
    .valid_id     (valid_id),
    .is_jal_id    (is_jal_id),
    .flush_id     (flush_id),
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  // Every word holds a distinct instruction; word 0x1000 (byte 0x4000) is a JAL.
  function automatic logic [31:0] mem_word(input logic [AW-1:0] w);
    return {w, 11'h2A5, (w == 14'h1000) ? OPC_JAL : OPC_ADDI};
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
`ifdef FETCH_PERF_EN
    chk({tag, "_redirect_cnt"}, redirect_cnt, exp_redir);
    chk({tag, "_stall_cnt"}, stall_cnt, exp_stall);
`else
    chk({tag, "_redirect_cnt"}, redirect_cnt, 32'd0);
    chk({tag, "_stall_cnt"}, stall_cnt, 32'd0);
`endif
  endtask

  // Called just after a rising edge: drive, check fetch side at negedge, check ID after the edge.
  task automatic step(input string tag, input logic s, input logic [1:0] sel,
                      input logic [31:0] jt, input logic [31:0] bt, input logic boot,
                      input logic exp_en, input logic [31:0] exp_fetch,
                      input logic exp_flush, input logic [31:0] exp_pc);
    exp_t e;
    exp_t got;
    stall      = s;
    pc_sel     = sel;
    jal_target = jt;
    br_target  = bt;
    @(negedge clk);
    chk({tag, "_imem_en"}, imem_en, exp_en);
    if (exp_en) chk({tag, "_imem_addr"}, imem_addr, exp_fetch[AW+1:2]);
    chk({tag, "_flush_id"}, flush_id, exp_flush);
    e.pc    = exp_pc;
    e.instr = mem_word(exp_pc[AW+1:2]);
    e.valid = 1'b1;
    e.jal   = (exp_pc[AW+1:2] == 14'h1000);
    sb.push_back(e);
    if (!boot && sel != 2'b00) exp_redir++;
    if (!boot && s) exp_stall++;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, "_pc_id"}, pc_id, got.pc);
    chk({tag, "_instr_id"}, instr_id, got.instr);
    chk({tag, "_valid_id"}, valid_id, got.valid);
    chk({tag, "_is_jal_id"}, is_jal_id, got.jal);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("reset_pc_id", pc_id, 32'd0);
    chk("reset_valid_id", valid_id, 1'b0);
    chk("reset_instr_id", instr_id, NOP);
    chk("reset_imem_en", imem_en, 1'b0);
    chk("reset_flush_id", flush_id, 1'b0);
    chk_counters("reset");

    @(posedge clk);
    #1 rst = 1'b0;
    chk("boot_valid_id", valid_id, 1'b0);
    // BOOT ignores stall and pc_sel
    step("boot", 1'b1, 2'b10, 32'd0, 32'h0000_9000, 1'b1, 1'b1, 32'h2000, 1'b0, 32'h2000);
    step("seq1", 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h2004, 1'b0, 32'h2004);

    // Stall three cycles holding 0x2004, then resume without loss or duplication
    step("stall1", 1'b1, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'h2008, 1'b0, 32'h2004);
    step("stall2", 1'b1, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'h2008, 1'b0, 32'h2004);
    step("stall3", 1'b1, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'h2008, 1'b0, 32'h2004);
    step("resume", 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h2008, 1'b0, 32'h2008);
    step("seq2", 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h200C, 1'b0, 32'h200C);
    step("seq3", 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h2010, 1'b0, 32'h2010);

    // Branch redirect with unaligned target
    step("branch", 1'b0, 2'b10, 32'd0, 32'h0000_3001, 1'b0, 1'b1, 32'h3000, 1'b1, 32'h3000);
    step("post_br", 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h3004, 1'b0, 32'h3004);

    // JAL redirect beats stall in the same cycle
    step("jal_stall", 1'b1, 2'b01, 32'h0000_4000, 32'd0, 1'b0, 1'b1, 32'h4000, 1'b1, 32'h4000);
    step("post_jal", 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h4004, 1'b0, 32'h4004);

    // Redirect while already in STALL leaves STALL
    step("stall_in", 1'b1, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'h4008, 1'b0, 32'h4004);
    step("br_in_stall", 1'b1, 2'b10, 32'd0, 32'h0000_5000, 1'b0, 1'b1, 32'h5000, 1'b1, 32'h5000);
    step("post_stall_br", 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h5004, 1'b0, 32'h5004);

    // Back-to-back redirects
    step("b2b_br", 1'b0, 2'b10, 32'd0, 32'h0000_6000, 1'b0, 1'b1, 32'h6000, 1'b1, 32'h6000);
    step("b2b_jal", 1'b0, 2'b01, 32'h0000_7002, 32'd0, 1'b0, 1'b1, 32'h7000, 1'b1, 32'h7000);
    step("post_b2b", 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h7004, 1'b0, 32'h7004);

    // +4 wrap and reserved pc_sel
    step("to_top", 1'b0, 2'b10, 32'd0, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC);
    step("wrap", 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000);
    step("sel11", 1'b0, 2'b11, 32'h0000_8000, 32'h0000_9000, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0004);

    // Reset asserted mid-stall
    step("pre_rst_stall1", 1'b1, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'h8, 1'b0, 32'h4);
    step("pre_rst_stall2", 1'b1, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'h8, 1'b0, 32'h4);
    chk_counters("pre_rst");
    #2 rst = 1'b1;
    #1;
    exp_redir = 0;
    exp_stall = 0;
    chk("async_rst_pc_id", pc_id, 32'd0);
    chk("async_rst_valid_id", valid_id, 1'b0);
    chk("async_rst_instr_id", instr_id, NOP);
    chk("async_rst_imem_en", imem_en, 1'b0);
    chk_counters("post_rst");

    @(posedge clk);
    #1 rst = 1'b0;
    step("reboot", 1'b0, 2'b01, 32'h0000_4000, 32'd0, 1'b1, 1'b1, 32'h2000, 1'b0, 32'h2000);
    step("reboot_seq", 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 32'h2004, 1'b0, 32'h2004);
    chk_counters("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
